ym_audio_dac: RTL and testbench

- Output stage directly downstream of the Sunsoft 5B/YM2149 expansion sound generator; consumes its 12-bit unsigned mixed sample.
- Low-pass filters the sample at a decimated rate and applies a click-free mute ramp.
- Produces a filtered 12-bit sample word with strobe for the cart audio mixer.
- Also produces a first-order delta-sigma 1-bit stream for the cartridge audio pin.

---
 rtl/ym_audio_dac.sv | 97 +++++++++
 tb/tb_ym_audio_dac.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/ym_audio_dac.sv
// ym_audio_dac: low-pass filter, mute ramp and delta-sigma output stage for the 5B/YM2149 expansion audio.
//   audio_clk  : sole clock, rising edge
//   map_enable : synchronous active-low reset
//   audio_in   : 12-bit unsigned sample, taken on each tick
//   mute       : 1 ramps gain to 0, 0 ramps gain to unity
//   sample_out : filtered, gain-scaled sample
//   sample_stb : one-cycle pulse when sample_out updates
//   dac_out    : 1-bit delta-sigma stream, density sample_out/4096
//   ramp_busy  : high while the gain ramp is moving
module ym_audio_dac #(
   parameter int DIV       = 16,
   parameter int LPF_SHIFT = 3
) (
   input  logic        audio_clk,
   input  logic        map_enable,
   input  logic [11:0] audio_in,
   input  logic        mute,
   output logic [11:0] sample_out,
   output logic        sample_stb,
   output logic        dac_out,
   output logic        ramp_busy
);
   localparam int CW = $clog2(DIV);
   localparam int AW = 12 + LPF_SHIFT;
   typedef enum logic [1:0] {MUTED, RAMP_UP, PLAY, RAMP_DOWN} state_t;
   state_t      r_state, w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [AW-1:0] r_lpf;
   logic [6:0]  r_gain, w_gain_nxt;
   logic        r_tick_d;
   logic [11:0] r_sample_out, r_ds;
   logic        r_stb, r_dac, r_busy;
   logic        w_tick;
   logic [AW-1:0] w_lpf_nxt;
   logic [11:0] w_filt, w_scaled;
   logic [12:0] w_ds_sum;
   assign w_tick     = r_cnt == CW'(DIV - 1);
   // accumulator holds 2^LPF_SHIFT * filtered value; the true result always fits AW bits
   assign w_lpf_nxt  = r_lpf + AW'(audio_in) - (r_lpf >> LPF_SHIFT);
   assign w_filt     = r_lpf[AW-1:LPF_SHIFT];
   assign w_scaled   = 12'((19'(w_filt) * 19'(r_gain)) >> 6);
   assign w_ds_sum   = {1'b0, r_ds} + {1'b0, r_sample_out};
   assign sample_out = r_sample_out;
   assign sample_stb = r_stb;
   assign dac_out    = r_dac;
   assign ramp_busy  = r_busy;
   // gain steps in the direction of the current state; mute changes redirect the state only
   always_comb begin
      w_state_nxt = r_state;
      w_gain_nxt  = r_gain;
      case (r_state)
         MUTED: begin
            w_gain_nxt = 7'd0;
            if (!mute) w_state_nxt = RAMP_UP;
         end
         RAMP_UP: begin
            if (w_tick && r_gain != 7'd64) w_gain_nxt = r_gain + 7'd1;
            if (mute) w_state_nxt = RAMP_DOWN;
            else if (w_tick && w_gain_nxt == 7'd64) w_state_nxt = PLAY;
         end
         PLAY: begin
            w_gain_nxt = 7'd64;
            if (mute) w_state_nxt = RAMP_DOWN;
         end
         default: begin
            if (w_tick && r_gain != 7'd0) w_gain_nxt = r_gain - 7'd1;
            if (!mute) w_state_nxt = RAMP_UP;
            else if (w_tick && w_gain_nxt == 7'd0) w_state_nxt = MUTED;
         end
      endcase
   end
   always_ff @(posedge audio_clk) begin
      if (!map_enable) begin
         r_state      <= MUTED;
         r_cnt        <= '0;
         r_lpf        <= '0;
         r_gain       <= 7'd0;
         r_tick_d     <= 1'b0;
         r_sample_out <= 12'd0;
         r_stb        <= 1'b0;
         r_ds         <= 12'd0;
         r_dac        <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_gain       <= w_gain_nxt;
         r_busy       <= w_state_nxt == RAMP_UP || w_state_nxt == RAMP_DOWN;
         r_cnt        <= w_tick ? '0 : r_cnt + 1'b1;
         r_lpf        <= w_tick ? w_lpf_nxt : r_lpf;
         r_tick_d     <= w_tick;
         r_stb        <= r_tick_d;
         r_sample_out <= r_tick_d ? w_scaled : r_sample_out;
         r_ds         <= w_ds_sum[11:0];
         r_dac        <= w_ds_sum[12];
      end
   end
endmodule

// File: tb/tb_ym_audio_dac.sv
// tb_ym_audio_dac: directed bench for ym_audio_dac with a cycle model and literal checkpoints.
module tb_ym_audio_dac;
   localparam int DIV = 4;
   localparam int SH  = 3;
   logic        clk = 1'b0, en = 1'b0, mute = 1'b0;
   logic [11:0] ain = 12'd0;
   logic [11:0] sout;
   logic        stb, dac, busy;
   int          n_chk = 0, n_fail = 0;
   bit          chk_en = 1'b0;
   int          m_cnt = 0, m_acc = 0, m_g = 0, m_out = 0, m_ds = 0;
   bit          m_pm = 1'b1, m_tick_d = 1'b0, m_stb = 1'b0, m_dac = 1'b0, m_busy = 1'b0;
   always #5 clk = ~clk;
   ym_audio_dac #(.DIV(DIV), .LPF_SHIFT(SH)) dut (
      .audio_clk(clk), .map_enable(en), .audio_in(ain), .mute(mute),
      .sample_out(sout), .sample_stb(stb), .dac_out(dac), .ramp_busy(busy)
   );
   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction
   // model: gain walks toward the target implied by last cycle's mute; busy while off target
   always @(posedge clk) begin
      int s, tgt;
      if (!en) begin
         m_cnt = 0; m_acc = 0; m_g = 0; m_pm = 1'b1; m_tick_d = 1'b0;
         m_out = 0; m_stb = 1'b0; m_ds = 0; m_dac = 1'b0; m_busy = 1'b0;
      end else begin
         s = m_ds + m_out;
         m_dac = s >= 4096;
         m_ds = s % 4096;
         m_stb = m_tick_d;
         if (m_tick_d) m_out = ((m_acc >> SH) * m_g) / 64;
         m_tick_d = m_cnt == DIV - 1;
         if (m_tick_d) begin
            m_acc = m_acc + int'(ain) - (m_acc >> SH);
            tgt = m_pm ? 0 : 64;
            m_g = m_g + (tgt > m_g ? 1 : 0) - (tgt < m_g ? 1 : 0);
         end
         m_pm = mute;
         m_busy = m_g != (mute ? 0 : 64);
         m_cnt = (m_cnt + 1) % DIV;
      end
   end
   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_sample_out", 32'(sout), 32'(m_out));
         chk("model_sample_stb", 32'(stb), 32'(m_stb));
         chk("model_dac_out", 32'(dac), 32'(m_dac));
         chk("model_ramp_busy", 32'(busy), 32'(m_busy));
      end
   end
   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic do_reset(input logic [11:0] a, input logic m);
      @(negedge clk);
      en = 1'b0; ain = a; mute = m;
      repeat (5) @(negedge clk);
      chk_en = 1'b1;
      chk("rst_out", 32'(sout), 0);
      chk("rst_stb", 32'(stb), 0);
      chk("rst_dac", 32'(dac), 0);
      chk("rst_busy", 32'(busy), 0);
      en = 1'b1;
   endtask
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end
   initial begin
      int k, p, dbl, ones, alt;
      bit prev;
      do_reset(12'd1000, 1'b0);
      k = 0;
      do begin @(negedge clk); k++; end while (!stb && k < 50);
      chk("first_stb_latency", 32'(k), 5);
      do_reset(12'd0, 1'b0);
      @(negedge clk);
      chk("busy_rise", 32'(busy), 1);
      k = 1;
      while (busy && k < 400) begin @(negedge clk); k++; end
      chk("busy_fall_cycle", 32'(k), 256);
      chk("silent_out", 32'(sout), 0);
      do_reset(12'd3825, 1'b0);
      wait_cycles(256 + 800);
      chk("dc_out", 32'(sout), 3825);
      p = 0; dbl = 0; prev = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         p += int'(stb);
         if (stb && prev) dbl++;
         prev = stb;
      end
      chk("stb_count", 32'(p), 4);
      chk("stb_width", 32'(dbl), 0);
      chk("dc_hold", 32'(sout), 3825);
      do_reset(12'd1000, 1'b0);
      wait_cycles(83);
      mute = 1'b1;
      wait_cycles(1);
      chk("rev_busy", 32'(busy), 1);
      k = 84;
      while (busy && k < 400) begin @(negedge clk); k++; end
      chk("rev_fall_cycle", 32'(k), 168);
      wait_cycles(8);
      chk("rev_out", 32'(sout), 0);
      do_reset(12'd2048, 1'b0);
      wait_cycles(256 + 1200);
      chk("ds_level", 32'(sout), 2048);
      ones = 0; alt = 0; prev = dac;
      for (int i = 0; i < 4096; i++) begin
         @(negedge clk);
         ones += int'(dac);
         if (dac == prev) alt++;
         prev = dac;
      end
      chk("ds_ones", 32'(ones), 2048);
      chk("ds_alternate", 32'(alt), 0);
      ain = 12'd0;
      wait_cycles(1000);
      chk("ds_zero_level", 32'(sout), 0);
      ones = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         ones += int'(dac);
      end
      chk("ds_zero_ones", 32'(ones), 0);
      do_reset(12'd1000, 1'b0);
      wait_cycles(256);
      mute = 1'b1;
      wait_cycles(136);
      chk("mid_busy", 32'(busy), 1);
      en = 1'b0;
      @(negedge clk);
      chk("mid_rst_out", 32'(sout), 0);
      chk("mid_rst_dac", 32'(dac), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_stb", 32'(stb), 0);
      wait_cycles(3);
      en = 1'b1;
      wait_cycles(100);
      chk("stay_muted_busy", 32'(busy), 0);
      chk("stay_muted_out", 32'(sout), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
